sockit_i2c_master_seq: RTL
==========================

Name: sockit_i2c_master_seq

Overview:
Byte-level I2C master sequencer. It accepts byte commands (optional START, 8-bit write or read, ACK bit, optional STOP) over a valid/ready interface. It generates open-drain SCL/SDA pull-down enables with a programmable quarter-bit prescaler and honours slave clock stretching. It sits between a register/CPU front end and the pad-level bufif1 open-drain drivers of the I2C bus.

Parameters:
DIV, 4, clk cycles per quarter-bit (must be >= 1)
DIV_W, 16, prescaler counter width

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
cmd_vld  input  1  command valid
cmd_rdy  output  1  command ready
cmd_start  input  1  issue START (or repeated START) before the byte
cmd_stop  input  1  issue STOP after the ACK bit
cmd_rw  input  1  1 = read byte, 0 = write byte
cmd_dat  input  8  write data, MSB first
cmd_ack  input  1  read only: 1 = master ACKs (SDA low), 0 = NACK
rsp_vld  output  1  one-cycle pulse when the byte's 9th bit completes
rsp_dat  output  8  SDA sampled on bits 7..0 (read data, or write readback)
rsp_ack  output  1  SDA sampled on 9th bit (0 = ACK)
busy  output  1  master owns the bus (state != IDLE)
scl_i  input  1  SCL line level, synchronous to clk
sda_i  input  1  SDA line level, synchronous to clk
scl_e  output  1  1 = pull SCL low
sda_e  output  1  1 = pull SDA low

Behaviour:
- Reset (sync): state = IDLE; scl_e = 0; sda_e = 0; rsp_vld = 0; rsp_dat = 0; rsp_ack = 0; prescaler = DIV-1. Applies mid-transfer: both lines are released on the next edge and no rsp_vld is issued.
- States: IDLE, START, BIT, STOP, HOLD. Each phase has 4 quarters Q0..Q3. The prescaler loads DIV-1 at each quarter start and the quarter ends when the counter reaches 0.
- cmd_rdy = 1 in IDLE and HOLD, else 0. A command is accepted on cmd_vld & cmd_rdy, and its fields are registered. The first quarter starts on the cycle after acceptance.
- From IDLE, START always runs; cmd_start is ignored because the bus is not owned. From HOLD, START runs only if cmd_start = 1.
- START:
  - Q0: sda_e = 0, scl_e unchanged.
  - Q1: scl_e = 0 (stretch).
  - Q2: sda_e = 1.
  - Q3: scl_e = 1.
  - Then BIT with bit index 8 (MSB).
- BIT (9 per command: indices 8..1 carry data, index 0 is the ACK bit):
  - Q0: scl_e = 1, sda_e set.
  - Q1: hold.
  - Q2: scl_e = 0 (stretch).
  - Q3: hold.
  - sda_e for data bits: write = ~data bit; read = 0.
  - sda_e for the ACK bit: write = 0; read = cmd_ack.
  - sda_i is sampled on the last cycle of Q2 and shifted into rsp_dat (bits 7..0) or rsp_ack (ACK bit).
- Stretch rule: in START Q1, BIT Q2 and STOP Q1, the counter does not decrement while scl_i == 0. No timeout.
- After the ACK bit's Q3:
  - rsp_vld pulses for 1 cycle.
  - rsp_dat and rsp_ack stay stable until the next rsp_vld.
  - Next state is STOP if cmd_stop, else HOLD.
- HOLD: scl_e = 1, sda_e unchanged, busy = 1. Waits for the next command.
- STOP:
  - Q0: scl_e = 1, sda_e = 1.
  - Q1: scl_e = 0 (stretch).
  - Q2: sda_e = 0.
  - Q3: hold.
  - Then IDLE, busy = 0.
- Timing, no stretch, with START and STOP: 44*DIV cycles from the first quarter to IDLE. rsp_vld fires 40*DIV cycles after the first quarter.
- A command presented while cmd_rdy = 0 is held off; cmd_vld must stay asserted (no drop).

Test Plan:
1. DIV=2, write 0xA5 with start+stop, slave ACKs → START seen (SDA falls while SCL high); SDA bits 1,0,1,0,0,1,0,1; rsp_vld 80 cycles after the first quarter with rsp_dat = 0xA5, rsp_ack = 0; IDLE after 88 cycles; busy low.
2. Read with start+stop, cmd_ack = 0, slave drives 0x3C → rsp_dat = 0x3C, rsp_ack = 1, sda_e = 0 throughout the 9th bit, then STOP (SDA rises while SCL high).
3. Write 0x90 with stop = 0 → HOLD with scl_e = 1 and cmd_rdy = 1. Then read with cmd_start = 1 → repeated START (SDA released while SCL low, then falls while SCL high) before the read bits.
4. Clock stretch: slave holds scl_i low for 10 cycles at bit 5 Q2 → prescaler frozen, rsp_vld delayed exactly 10 cycles versus scenario 1, data unchanged.
5. Write 0x55, slave leaves SDA high on the ACK bit → rsp_ack = 1, rsp_dat = 0x55; STOP still executes when cmd_stop = 1.
6. Assert rst in the middle of bit 3 → scl_e = sda_e = 0 and cmd_rdy = 1 on the next cycle, no rsp_vld, busy = 0; a new command then starts with a full START.

Source files
------------

// File: rtl/sockit_i2c_master_seq.sv
// Byte-level I2C master sequencer.
// Runs START / 9 bit slots / STOP phases of four prescaled quarters each and
// drives open-drain pull-down enables for SCL and SDA. Slave clock stretching
// freezes the prescaler in the quarters where SCL has just been released.
module sockit_i2c_master_seq #(
    parameter int unsigned DIV   = 4,
    parameter int unsigned DIV_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    // Command handshake: a command transfers on any clk edge where
    // cmd_vld & cmd_rdy are both 1. Once raised, cmd_vld stays high with
    // stable fields until that edge. cmd_rdy does not depend on cmd_vld.
    input  logic       cmd_vld,
    output logic       cmd_rdy,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_dat,
    input  logic       cmd_ack,
    output logic       rsp_vld,
    output logic [7:0] rsp_dat,
    output logic       rsp_ack,
    output logic       busy,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_e,
    output logic       sda_e,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BIT   = 3'd2,
        S_STOP  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    localparam logic [DIV_W-1:0] PRE_LOAD = DIV_W'(DIV - 1);

    state_t           state_q, state_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic             scl_e_q, scl_e_d;
    logic             sda_e_q, sda_e_d;
    logic [7:0]       shf_q, shf_d;
    logic             ack_s_q, ack_s_d;
    logic             rsp_vld_q, rsp_vld_d;
    logic [7:0]       rsp_dat_q, rsp_dat_d;
    logic             rsp_ack_q, rsp_ack_d;
    logic             c_stop_q, c_stop_d;
    logic             c_rw_q, c_rw_d;
    logic [7:0]       c_dat_q, c_dat_d;
    logic             c_ack_q, c_ack_d;

    logic accept;
    logic stretch_qtr;
    logic stall;
    logic q_end;

    // SDA pull-down for a bit slot: index 0 is the ACK slot, 8..1 carry data MSB first.
    function automatic logic drive_bit(input logic rw, input logic [7:0] dat,
                                       input logic ack, input logic [3:0] idx);
        logic [2:0] b;
        b = 3'(idx - 4'd1);
        if (idx == 4'd0) return rw ? ack : 1'b0;
        else             return rw ? 1'b0 : ~dat[b];
    endfunction

    assign cmd_rdy     = (state_q == S_IDLE) || (state_q == S_HOLD);
    assign accept      = cmd_vld && cmd_rdy;
    assign busy        = (state_q != S_IDLE);
    assign stretch_qtr = ((state_q == S_START) && (qtr_q == 2'd1)) ||
                         ((state_q == S_BIT)   && (qtr_q == 2'd2)) ||
                         ((state_q == S_STOP)  && (qtr_q == 2'd1));
    assign stall       = stretch_qtr && !scl_i;
    assign q_end       = (cnt_q == '0) && !stall;

    assign scl_e     = scl_e_q;
    assign sda_e     = sda_e_q;
    assign rsp_vld   = rsp_vld_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_ack   = rsp_ack_q;
    assign dbg_state = state_q;

    // Next-state, quarter sequencing and line-enable updates at quarter boundaries.
    always_comb begin
        state_d   = state_q;
        qtr_d     = qtr_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        scl_e_d   = scl_e_q;
        sda_e_d   = sda_e_q;
        shf_d     = shf_q;
        ack_s_d   = ack_s_q;
        rsp_vld_d = 1'b0;
        rsp_dat_d = rsp_dat_q;
        rsp_ack_d = rsp_ack_q;
        c_stop_d  = c_stop_q;
        c_rw_d    = c_rw_q;
        c_dat_d   = c_dat_q;
        c_ack_d   = c_ack_q;

        if (accept) begin
            c_stop_d = cmd_stop;
            c_rw_d   = cmd_rw;
            c_dat_d  = cmd_dat;
            c_ack_d  = cmd_ack;
        end

        case (state_q)
            S_IDLE: begin
                // Bus not owned yet, so a START is always generated.
                if (accept) begin
                    state_d = S_START;
                    qtr_d   = 2'd0;
                    cnt_d   = PRE_LOAD;
                    sda_e_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (accept) begin
                    qtr_d = 2'd0;
                    cnt_d = PRE_LOAD;
                    if (cmd_start) begin
                        state_d = S_START;
                        sda_e_d = 1'b0;
                    end else begin
                        state_d = S_BIT;
                        idx_d   = 4'd8;
                        scl_e_d = 1'b1;
                        sda_e_d = drive_bit(cmd_rw, cmd_dat, cmd_ack, 4'd8);
                    end
                end
            end
            default: begin
                if (!q_end) begin
                    if (!stall) cnt_d = cnt_q - DIV_W'(1);
                end else begin
                    cnt_d = PRE_LOAD;
                    qtr_d = qtr_q + 2'd1;
                    case (state_q)
                        S_START: begin
                            case (qtr_q)
                                2'd0:    scl_e_d = 1'b0;
                                2'd1:    sda_e_d = 1'b1;
                                2'd2:    scl_e_d = 1'b1;
                                default: begin
                                    state_d = S_BIT;
                                    qtr_d   = 2'd0;
                                    idx_d   = 4'd8;
                                    scl_e_d = 1'b1;
                                    sda_e_d = drive_bit(c_rw_q, c_dat_q, c_ack_q, 4'd8);
                                end
                            endcase
                        end
                        S_BIT: begin
                            case (qtr_q)
                                2'd0:    begin end
                                2'd1:    scl_e_d = 1'b0;
                                2'd2: begin
                                    // Last cycle of the SCL-high quarter: sample SDA.
                                    if (idx_q != 4'd0) shf_d   = {shf_q[6:0], sda_i};
                                    else               ack_s_d = sda_i;
                                end
                                default: begin
                                    qtr_d   = 2'd0;
                                    scl_e_d = 1'b1;
                                    if (idx_q == 4'd0) begin
                                        rsp_vld_d = 1'b1;
                                        rsp_dat_d = shf_q;
                                        rsp_ack_d = ack_s_q;
                                        if (c_stop_q) begin
                                            state_d = S_STOP;
                                            sda_e_d = 1'b1;
                                        end else begin
                                            state_d = S_HOLD;
                                        end
                                    end else begin
                                        idx_d   = idx_q - 4'd1;
                                        sda_e_d = drive_bit(c_rw_q, c_dat_q, c_ack_q, idx_q - 4'd1);
                                    end
                                end
                            endcase
                        end
                        default: begin
                            case (qtr_q)
                                2'd0:    scl_e_d = 1'b0;
                                2'd1:    sda_e_d = 1'b0;
                                2'd2:    begin end
                                default: begin
                                    state_d = S_IDLE;
                                    qtr_d   = 2'd0;
                                end
                            endcase
                        end
                    endcase
                end
            end
        endcase
    end

    // State register with synchronous reset that releases both lines immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            qtr_q     <= 2'd0;
            cnt_q     <= PRE_LOAD;
            idx_q     <= 4'd0;
            scl_e_q   <= 1'b0;
            sda_e_q   <= 1'b0;
            shf_q     <= 8'h00;
            ack_s_q   <= 1'b0;
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= 8'h00;
            rsp_ack_q <= 1'b0;
            c_stop_q  <= 1'b0;
            c_rw_q    <= 1'b0;
            c_dat_q   <= 8'h00;
            c_ack_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            qtr_q     <= qtr_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            scl_e_q   <= scl_e_d;
            sda_e_q   <= sda_e_d;
            shf_q     <= shf_d;
            ack_s_q   <= ack_s_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_ack_q <= rsp_ack_d;
            c_stop_q  <= c_stop_d;
            c_rw_q    <= c_rw_d;
            c_dat_q   <= c_dat_d;
            c_ack_q   <= c_ack_d;
        end
    end

endmodule
